// File: rtl/csa_resolver.sv
// csa_resolver: resolves a redundant (sum, carry) pair into one binary result,
// CHUNK bits per cycle, with a registered carry between slices.
// Optional leading-zero count: define CSA_RESOLVER_LZC_EN to add out_lzc.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE. out_valid is high only in DONE, and
// out_result/out_cout/out_lzc are held there until out_ready is seen.
module csa_resolver #(
    parameter int WIDTH = 106,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
`ifdef CSA_RESOLVER_LZC_EN
    output logic [$clog2(WIDTH+1)-1:0] out_lzc,
`endif
    output logic [1:0]       dbg_state_o
);

    localparam int NSLICE = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int LASTW  = WIDTH - (NSLICE - 1) * CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int LZW    = $clog2(WIDTH + 1);
    // Bits of the final slice that actually belong to the operands.
    localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LASTW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             cbit_q, cbit_d;
    logic [WIDTH-1:0] op_sum_q, op_sum_d;
    logic [WIDTH-1:0] op_carry_q, op_carry_d;
    logic [WIDTH-1:0] result_q, result_d;

    int               base;
    logic             is_last;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] valid_mask;
    logic [CHUNK:0]   slice_sum;
    logic [CHUNK-1:0] slice_bits;
    logic             slice_cout;
    logic [WIDTH-1:0] merged;

`ifdef CSA_RESOLVER_LZC_EN
    logic [LZW-1:0]   lzc_q, lzc_d;
    logic             slice_nz;
    int               top_pos;
    logic [LZW-1:0]   lzc_slice;
`endif

    // Slice adder: add slice idx of both operands plus the carry from the slice below.
    always_comb begin
        base       = int'(idx_q) * CHUNK;
        is_last    = (idx_q == IDXW'(NSLICE - 1));
        slice_a    = CHUNK'(op_sum_q >> base);
        slice_b    = CHUNK'(op_carry_q >> base);
        valid_mask = is_last ? LAST_MASK : {CHUNK{1'b1}};
        slice_sum  = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, cbit_q};
        slice_bits = slice_sum[CHUNK-1:0] & valid_mask;
        // In a narrow last slice the carry out of bit WIDTH-1 lands at LASTW.
        slice_cout = is_last ? slice_sum[LASTW] : slice_sum[CHUNK];
        merged     = (result_q & ~(WIDTH'(valid_mask) << base)) | (WIDTH'(slice_bits) << base);
    end

`ifdef CSA_RESOLVER_LZC_EN
    // Leading-zero position inside the current slice; higher slices overwrite lower ones.
    always_comb begin
        slice_nz = |slice_bits;
        top_pos  = 0;
        for (int i = 0; i < CHUNK; i++) begin
            if (slice_bits[i]) top_pos = i;
        end
        lzc_slice = LZW'(WIDTH - base - top_pos - 1);
    end
`endif

    // Next-state and handshake logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cbit_d     = cbit_q;
        op_sum_d   = op_sum_q;
        op_carry_d = op_carry_q;
        result_d   = result_q;
`ifdef CSA_RESOLVER_LZC_EN
        lzc_d      = lzc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d    = S_BUSY;
                    op_sum_d   = in_sum;
                    op_carry_d = in_carry;
                    idx_d      = '0;
                    cbit_d     = 1'b0;
`ifdef CSA_RESOLVER_LZC_EN
                    // An all-zero result leaves the count at WIDTH.
                    lzc_d      = LZW'(WIDTH);
`endif
                end
            end
            S_BUSY: begin
                result_d = merged;
                cbit_d   = slice_cout;
`ifdef CSA_RESOLVER_LZC_EN
                if (slice_nz) lzc_d = lzc_slice;
`endif
                if (is_last) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cbit_q     <= 1'b0;
            op_sum_q   <= '0;
            op_carry_q <= '0;
            result_q   <= '0;
`ifdef CSA_RESOLVER_LZC_EN
            lzc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cbit_q     <= cbit_d;
            op_sum_q   <= op_sum_d;
            op_carry_q <= op_carry_d;
            result_q   <= result_d;
`ifdef CSA_RESOLVER_LZC_EN
            lzc_q      <= lzc_d;
`endif
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_result  = result_q;
    // The carry register holds the carry out of bit WIDTH-1 once the last slice is done.
    assign out_cout    = cbit_q;
    assign dbg_state_o = state_q;
`ifdef CSA_RESOLVER_LZC_EN
    assign out_lzc     = lzc_q;
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Directed testbench for csa_resolver: default 106/32 instance plus an 8/3
// instance exercising the narrow last slice.
module tb_csa_resolver;

    localparam int W   = 106;
    localparam int LZW = $clog2(W + 1);
    localparam int SW  = 8;
    localparam int SLZ = $clog2(SW + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // main instance
    logic         in_valid, in_ready, out_valid, out_ready, out_cout;
    logic [W-1:0] in_sum, in_carry, out_result;
    logic [1:0]   dbg_state;
    logic [LZW-1:0] out_lzc;

    // small instance
    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_cout;
    logic [SW-1:0] s_in_sum, s_in_carry, s_out_result;
    logic [1:0]    s_dbg_state;
    logic [SLZ-1:0] s_out_lzc;

    csa_resolver #(.WIDTH(W), .CHUNK(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout),
`ifdef CSA_RESOLVER_LZC_EN
        .out_lzc(out_lzc),
`endif
        .dbg_state_o(dbg_state)
    );

    csa_resolver #(.WIDTH(SW), .CHUNK(3)) u_dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_sum(s_in_sum), .in_carry(s_in_carry),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_result(s_out_result), .out_cout(s_out_cout),
`ifdef CSA_RESOLVER_LZC_EN
        .out_lzc(s_out_lzc),
`endif
        .dbg_state_o(s_dbg_state)
    );

`ifndef CSA_RESOLVER_LZC_EN
    assign out_lzc   = '0;
    assign s_out_lzc = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard for the streaming test: {cout, result}
    logic [W:0] exp_q[$];

    // ---------------- driver tasks ----------------
    // Present an operand pair and return just after the accepting edge.
    task automatic send_op(input logic [W-1:0] s, input logic [W-1:0] c, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_sum   = s;
            in_carry = c;
            in_valid = 1'b1;
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                break;
            end
        end
    endtask

    // Wait at negedges for out_valid; lat = edges since the accept edge, -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = k;
                break;
            end
            @(posedge clk);
        end
    endtask

    // Accept the pending result; returns at the negedge after the accept edge.
    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        n_tests++;
        if (out_result !== '0 || out_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_result: result=%h cout=%b, required 0/0", out_result, out_cout);
        end
        n_tests++;
        if (dbg_state !== 2'd0 || s_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d small_ready=%b, required 0/1", dbg_state, s_in_ready);
        end
`ifdef CSA_RESOLVER_LZC_EN
        n_tests++;
        if (out_lzc !== '0) begin
            n_fail++;
            $display("FAIL reset_lzc: lzc=%0d, required 0", out_lzc);
        end
`endif
    endtask

    task automatic test_wrap();
        bit ok;
        int lat;
        send_op(W'(1), {W{1'b1}}, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wrap_accept: in_ready never seen, required accept");
        end
        wait_done(lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL wrap_latency: %0d edges, required 4", lat);
        end
        n_tests++;
        if (out_result !== '0 || out_cout !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_result: result=%h cout=%b, required 0/1", out_result, out_cout);
        end
`ifdef CSA_RESOLVER_LZC_EN
        n_tests++;
        if (out_lzc !== LZW'(106)) begin
            n_fail++;
            $display("FAIL wrap_lzc: lzc=%0d, required 106", out_lzc);
        end
`endif
        release_out();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_ripple();
        bit ok;
        int lat;
        logic [W-1:0] exp;
        exp = {{(W-33){1'b0}}, 1'b1, 32'h0};
        send_op(W'(32'hFFFF_FFFF), W'(1), ok);
        wait_done(lat);
        n_tests++;
        if (out_result !== exp || out_cout !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL ripple_result: result=%h cout=%b lat=%0d, required %h/0/4", out_result, out_cout, lat, exp);
        end
`ifdef CSA_RESOLVER_LZC_EN
        n_tests++;
        if (out_lzc !== LZW'(73)) begin
            n_fail++;
            $display("FAIL ripple_lzc: lzc=%0d, required 73", out_lzc);
        end
`endif
        release_out();
    endtask

    task automatic test_all_ones();
        bit ok;
        int lat;
        send_op({53{2'b10}}, {53{2'b01}}, ok);
        wait_done(lat);
        n_tests++;
        if (out_result !== {W{1'b1}} || out_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_result: result=%h cout=%b, required all-ones/0", out_result, out_cout);
        end
`ifdef CSA_RESOLVER_LZC_EN
        n_tests++;
        if (out_lzc !== '0) begin
            n_fail++;
            $display("FAIL ones_lzc: lzc=%0d, required 0", out_lzc);
        end
`endif
        release_out();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [W-1:0] exp;
        exp = W'(66'h3_0000_0000_0000_0003);
        send_op(W'(66'h2_0000_0000_0000_0001), W'(66'h1_0000_0000_0000_0002), ok);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== exp || out_cout !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b result=%h cout=%b, required 1/0/%h/0",
                         i, out_valid, in_ready, out_result, out_cout, exp);
            end
`ifdef CSA_RESOLVER_LZC_EN
            n_tests++;
            if (out_lzc !== LZW'(40)) begin
                n_fail++;
                $display("FAIL bp_lzc%0d: lzc=%0d, required 40", i, out_lzc);
            end
`endif
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_sum   = {W{1'b1}};
            in_carry = W'(7);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_out();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b state=%0d, required 0/1/0", out_valid, in_ready, dbg_state);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit seen;
        send_op(W'(5), W'(9), ok);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (dbg_state !== 2'd1) begin
            n_fail++;
            $display("FAIL midrst_busy: state=%0d, required 1", dbg_state);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: ready=%b valid=%b result=%h cout=%b, required 1/0/0/0",
                     in_ready, out_valid, out_result, out_cout);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_dropped: out_valid=%b seen, required 0", seen);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] ss[3];
        logic [W-1:0] cc[3];
        logic [W:0]   ee[3];
        logic [W:0]   exp;
        int  k, got, last_cyc;
        bit  rdy;
        ss[0] = {1'b1, {(W-1){1'b0}}};  cc[0] = {1'b1, {(W-1){1'b0}}};  ee[0] = {1'b1, {W{1'b0}}};
        ss[1] = {{(W-64){1'b0}}, {64{1'b1}}}; cc[1] = W'(1); ee[1] = {1'b0, {(W-65){1'b0}}, 1'b1, 64'h0};
        ss[2] = W'(12345); cc[2] = W'(54321); ee[2] = {1'b0, W'(66666)};
        k = 0; got = 0; last_cyc = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_unexpected: result=%h with empty queue, required none", out_result);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_cout, out_result} !== exp) begin
                        n_fail++;
                        $display("FAIL stream_result%0d: got %h, required %h", got, {out_cout, out_result}, exp);
                    end
                end
                if (got > 0) begin
                    n_tests++;
                    if (cyc - last_cyc != 6) begin
                        n_fail++;
                        $display("FAIL stream_period%0d: %0d cycles, required 6", got, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            rdy = in_ready;
            if (k < 3) begin
                in_valid = 1'b1;
                in_sum   = ss[k];
                in_carry = cc[k];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            if (rdy && k < 3) begin
                exp_q.push_back(ee[k]);
                k++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL stream_count: %0d results, required 3", got);
        end
    endtask

    task automatic test_small();
        logic [SW-1:0] ss[2];
        logic [SW-1:0] cc[2];
        logic [SW:0]   ee[2];
        logic [SLZ-1:0] el[2];
        int busy;
        ss[0] = 8'hFF; cc[0] = 8'h01; ee[0] = 9'h100; el[0] = SLZ'(8);
        ss[1] = 8'h5A; cc[1] = 8'h26; ee[1] = 9'h080; el[1] = SLZ'(0);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            s_in_sum   = ss[t];
            s_in_carry = cc[t];
            s_in_valid = 1'b1;
            n_tests++;
            if (s_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL small_ready%0d: in_ready=%b, required 1", t, s_in_ready);
            end
            @(posedge clk);
            busy = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                s_in_valid = 1'b0;
                if (s_out_valid) break;
                if (s_dbg_state == 2'd1) busy++;
                @(posedge clk);
            end
            n_tests++;
            if (busy != 3 || s_out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL small_busy%0d: busy=%0d valid=%b, required 3/1", t, busy, s_out_valid);
            end
            n_tests++;
            if ({s_out_cout, s_out_result} !== ee[t]) begin
                n_fail++;
                $display("FAIL small_result%0d: got %h, required %h", t, {s_out_cout, s_out_result}, ee[t]);
            end
`ifdef CSA_RESOLVER_LZC_EN
            n_tests++;
            if (s_out_lzc !== el[t]) begin
                n_fail++;
                $display("FAIL small_lzc%0d: lzc=%0d, required %0d", t, s_out_lzc, el[t]);
            end
`endif
            s_out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            s_out_ready = 1'b0;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_sum      = '0;
        in_carry    = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_sum    = '0;
        s_in_carry  = '0;
        s_out_ready = 1'b0;
        test_reset();
        test_wrap();
        test_ripple();
        test_all_ones();
        test_backpressure();
        test_mid_reset();
        test_stream();
        test_small();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
